// File: rtl/mem_access_sequencer.sv
// Load/store memory access sequencer: IDLE -> ACCESS -> DONE handshake with a single-cycle done pulse.
// Optional ACCESS timeout with err reporting is compiled in when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned PC_W        = 8,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op_code,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] result_out,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] result_q;
  logic              is_str_q;
  logic              alu_hold;
  logic              is_mem_op;
  logic              accept;
  logic              tmo_hit;
  logic              unused_src1;

  // Only the low ADDR_W bits of src1 address memory.
  assign unused_src1 = ^src1;

  assign is_mem_op  = (op_code == OP_LDR) || (op_code == OP_STR);
  assign accept     = (state == IDLE) && start;
  assign result_out = result_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (state == ACCESS) && !mem_ack &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if ((state == ACCESS) && !mem_ack) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      is_str_q <= 1'b0;
      alu_hold <= 1'b0;
    end else begin
      state    <= state_nxt;
      alu_hold <= 1'b0;
      if (accept) begin
        if (is_mem_op) begin
          addr_q   <= src1[ADDR_W-1:0];
          wdata_q  <= src2;
          is_str_q <= (op_code == OP_STR);
        end else begin
          result_q <= alu_result;
          alu_hold <= 1'b1;
        end
      end
      if ((state == ACCESS) && mem_ack && !is_str_q) result_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ADDR_W'(pc);
    mem_wdata = '0;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = is_mem_op ? ACCESS : DONE;
      end
      ACCESS: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr_q;
        mem_we   = is_str_q;
        if (is_str_q) mem_wdata = wdata_q;
        if (mem_ack || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        // Non-memory ops spend an extra settle cycle in DONE so their
        // start-to-done latency matches a zero-wait LDR/STR.
        busy = 1'b1;
        done = !alu_hold;
        if (!alu_hold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer (timeout scenario when MEM_ACCESS_TIMEOUT_EN is defined).
module tb_mem_access_sequencer;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;
  localparam logic [3:0] OP_ALU = 4'b0001;

  logic        clk = 1'b0;
  logic        reset, start, mem_req, mem_we, mem_ack, done, busy, err;
  logic [3:0]  op_code;
  logic [7:0]  pc;
  logic [31:0] src1, src2, alu_result, mem_wdata, mem_rdata, result_out;
  logic [15:0] mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_sequencer #(
    .DATA_W(32), .ADDR_W(16), .PC_W(8), .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op_code(op_code), .pc(pc),
    .src1(src1), .src2(src2), .alu_result(alu_result),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .result_out(result_out), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; op_code = '0; pc = 8'h3C;
    src1 = '0; src2 = '0; alu_result = '0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (result_out !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result_out); end
    n_checks++; if ({done, busy, err, mem_req, mem_we} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {done, busy, err, mem_req, mem_we}); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    n_checks++; if (mem_addr !== 16'h003C) begin n_fail++; $display("FAIL reset_addr_pc: got %h expected 003c", mem_addr); end
  endtask

  task automatic test_ldr_immediate();
    op_code = OP_LDR; src1 = 32'h0000_0001; mem_rdata = 32'hFFFF_FFFF; mem_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({mem_req, mem_we, busy, done} !== 4'b1010) begin n_fail++; $display("FAIL ldr_access_flags: got %b expected 1010", {mem_req, mem_we, busy, done}); end
    n_checks++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL ldr_addr: got %h expected 0001", mem_addr); end
    tick();
    n_checks++; if ({done, mem_req} !== 2'b10) begin n_fail++; $display("FAIL ldr_done_c2: got %b expected 10", {done, mem_req}); end
    n_checks++; if (result_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ldr_result: got %h expected ffffffff", result_out); end
    tick();
    // ack still high in IDLE must have no effect
    n_checks++; if ({done, busy, mem_req} !== 3'b000) begin n_fail++; $display("FAIL ldr_back_idle: got %b expected 000", {done, busy, mem_req}); end
    mem_ack = 1'b0;
  endtask

  task automatic test_str_wait();
    op_code = OP_STR; src1 = 32'h0001_0003; src2 = 32'h5; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      start = 1'b0;
      n_checks++;
      if ({mem_req, mem_we, done} !== 3'b110 || mem_addr !== 16'h0003 || mem_wdata !== 32'h5) begin
        n_fail++;
        $display("FAIL str_hold_c%0d: got req/we/done=%b addr=%h wdata=%h expected 110 0003 00000005",
                 i, {mem_req, mem_we, done}, mem_addr, mem_wdata);
      end
      if (i == 4) mem_ack = 1'b1;
    end
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({done, mem_req, mem_we} !== 3'b100) begin n_fail++; $display("FAIL str_done_c5: got %b expected 100", {done, mem_req, mem_we}); end
    n_checks++; if (result_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL str_result_kept: got %h expected ffffffff", result_out); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL str_wdata_idle: got %h expected 0", mem_wdata); end
    tick();
  endtask

  task automatic test_alu();
    int req_seen = 0;
    op_code = OP_ALU; alu_result = 32'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    req_seen += int'(mem_req);
    n_checks++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL alu_c1: got done/busy=%b expected 01", {done, busy}); end
    tick();
    req_seen += int'(mem_req);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL alu_done_c2: got %b expected 1", done); end
    n_checks++; if (result_out !== 32'hA5) begin n_fail++; $display("FAIL alu_result: got %h expected 000000a5", result_out); end
    tick();
    req_seen += int'(mem_req);
    n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL alu_idle: got %b expected 00", {done, busy}); end
    n_checks++; if (req_seen !== 0) begin n_fail++; $display("FAIL alu_no_req: got %0d req cycles expected 0", req_seen); end
  endtask

  task automatic test_reset_mid_access();
    int dones = 0;
    op_code = OP_LDR; src1 = 32'h20; mem_rdata = 32'h1234_5678; pc = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // reset and ack on the same edge: reset must win
    reset = 1'b1; mem_ack = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({mem_req, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", {mem_req, busy, done}); end
    n_checks++; if (result_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 0", result_out); end
    n_checks++; if (mem_addr !== 16'h0077) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected 0077", mem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      dones += int'(done);
    end
    mem_ack = 1'b0;
    n_checks++; if (dones !== 0 || result_out !== 32'h0) begin n_fail++; $display("FAIL rst_late_ack: got dones=%0d result=%h expected 0 0", dones, result_out); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    op_code = OP_STR; src1 = 32'h44; src2 = 32'h99; start = 1'b1;
    tick();
    op_code = OP_ALU; alu_result = 32'hDEAD;
    tick();
    mem_ack = 1'b1;
    n_checks++; if (mem_addr !== 16'h0044 || mem_wdata !== 32'h99) begin n_fail++; $display("FAIL b2b_captured: got addr=%h wdata=%h expected 0044 00000099", mem_addr, mem_wdata); end
    tick();
    mem_ack = 1'b0;
    dones += int'(done);
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_not_queued: got busy=%b expected 0", busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      dones += int'(done);
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", dones); end
    n_checks++; if (result_out !== 32'h0) begin n_fail++; $display("FAIL b2b_result: got %h expected 0", result_out); end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    int done_cyc = -1;
    op_code = OP_LDR; src1 = 32'h10; mem_rdata = 32'hCAFE; mem_ack = 1'b0; start = 1'b1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      tick();
      start = 1'b0;
      if (done) begin
        done_cyc = c;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", err); end
        n_checks++; if (result_out !== 32'h0) begin n_fail++; $display("FAIL tmo_result: got %h expected 0", result_out); end
      end
    end
    n_checks++; if (done_cyc !== 16) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 16", done_cyc); end
    tick();
    op_code = OP_ALU; alu_result = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b expected 0", err); end
    tick(); tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    op_code = OP_LDR; src1 = 32'h10; mem_rdata = 32'hCAFE; mem_ack = 1'b0; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      if (done !== 1'b0 || err !== 1'b0 || mem_req !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL long_wait: got %0d bad cycles expected 0", bad); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || result_out !== 32'hCAFE) begin n_fail++; $display("FAIL long_wait_done: got done=%b err=%b result=%h expected 1 0 0000cafe", done, err, result_out); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_ldr_immediate();
    test_str_wait();
    test_alu();
    test_reset_mid_access();
    test_back_to_back();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
